// File: rtl/mod2011_pkg.sv
// Shared constants and types for the mod-2011 residue datapath.
package mod2011_pkg;

    localparam logic [10:0] MOD_2011 = 11'd2011;
    localparam int unsigned RES_W    = 11;

    typedef logic [RES_W-1:0] res_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } acc_state_e;

endpackage

// File: rtl/mod2011_residue_acc_if.sv
// Term stream in, frame residue out, for the mod-2011 residue accumulator.
interface mod2011_residue_acc_if
    import mod2011_pkg::*;
#(
    parameter int unsigned W  = RES_W,
    parameter int unsigned CW = 8
);

    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [CW-1:0] m_count;
    logic          m_range_err;

    // Producer/consumer side: drives terms, accepts results.
    modport master (
        output s_valid,
        output s_data,
        output s_last,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data,
        input  m_count,
        input  m_range_err
    );

    // Accumulator side.
    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data,
        output m_count,
        output m_range_err
    );

endinterface

// File: rtl/mod2011_add.sv
// Combinational modular adder: y = (a + b) mod MOD for a, b < MOD.
module mod2011_add
    import mod2011_pkg::*;
#(
    parameter int unsigned MOD = MOD_2011,
    parameter int unsigned W   = RES_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    localparam logic [W-1:0] ModW = W'(MOD);

    logic [W:0] sum;
    logic       wrap;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign wrap = (sum >= {1'b0, ModW});
    // The reduced sum is below MOD, so the low W bits carry the whole result.
    assign y    = wrap ? (sum[W-1:0] - ModW) : sum[W-1:0];

endmodule

// File: rtl/mod2011_residue_acc.sv
// Streaming mod-2011 accumulator: sums per-chunk partial residues and emits
// one fully reduced residue, term count and range flag per frame.
module mod2011_residue_acc
    import mod2011_pkg::*;
#(
    parameter int unsigned MOD = MOD_2011,
    parameter int unsigned W   = RES_W,
    parameter int unsigned CW  = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    mod2011_residue_acc_if.slave bus
);

    localparam logic [W-1:0]  ModW   = W'(MOD);
    localparam logic [CW-1:0] CntMax = {CW{1'b1}};

    acc_state_e    state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic [W-1:0]  m_data_q, m_data_d;
    logic [CW-1:0] m_count_q, m_count_d;
    logic          m_err_q, m_err_d;

    logic          beat;
    logic          term_err;
    logic [W-1:0]  term_red;
    logic [W-1:0]  acc_sum;
    logic [CW-1:0] cnt_inc;

    assign beat     = bus.s_valid && s_ready_q;

    // One subtraction suffices since 2^W - 1 < 2*MOD.
    assign term_err = (bus.s_data >= ModW);
    assign term_red = term_err ? (bus.s_data - ModW) : bus.s_data;
    assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    mod2011_add #(
        .MOD (MOD),
        .W   (W)
    ) u_add (
        .a (acc_q),
        .b (term_red),
        .y (acc_sum)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        m_data_d  = m_data_q;
        m_count_d = m_count_q;
        m_err_d   = m_err_q;

        unique case (state_q)
            StIdle, StAccum: begin
                if (beat) begin
                    if (bus.s_last) begin
                        m_data_d  = acc_sum;
                        m_count_d = cnt_inc;
                        m_err_d   = err_q | term_err;
                        acc_d     = '0;
                        cnt_d     = '0;
                        err_d     = 1'b0;
                        state_d   = StDone;
                    end else begin
                        acc_d   = acc_sum;
                        cnt_d   = cnt_inc;
                        err_d   = err_q | term_err;
                        state_d = StAccum;
                    end
                end
            end
            StDone: begin
                if (bus.m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Handshake outputs are registered copies of the next-state decode.
        s_ready_d = (state_d != StDone);
        m_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_count_q <= '0;
            m_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_count_q <= m_count_d;
            m_err_q   <= m_err_d;
        end
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_data      = m_data_q;
    assign bus.m_count     = m_count_q;
    assign bus.m_range_err = m_err_q;

endmodule

// File: tb/tb_mod2011_residue_acc.sv
// Directed bench for mod2011_residue_acc with hand-computed expectations.
module tb_mod2011_residue_acc;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mod2011_residue_acc_if #(.W(11), .CW(8)) bus ();

    mod2011_residue_acc #(
        .MOD (2011),
        .W   (11),
        .CW  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one term, wait (bounded) for s_ready, let one edge take it.
    task automatic send(input logic [10:0] d, input logic last);
        int k;
        k = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        while (!bus.s_ready && k < 8) begin
            step();
            k++;
        end
        chk("send_ready", {31'd0, bus.s_ready}, 32'd1);
        step();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // Wait (bounded) for a result, check it, then consume it.
    task automatic recv(input string tag, input logic [10:0] d, input logic [7:0] c,
                        input logic e);
        int k;
        k = 0;
        while (!bus.m_valid && k < 8) begin
            step();
            k++;
        end
        chk({tag, "_valid"}, {31'd0, bus.m_valid}, 32'd1);
        chk({tag, "_data"}, {21'd0, bus.m_data}, {21'd0, d});
        chk({tag, "_count"}, {24'd0, bus.m_count}, {24'd0, c});
        chk({tag, "_err"}, {31'd0, bus.m_range_err}, {31'd0, e});
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk({tag, "_drop"}, {31'd0, bus.m_valid}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, bus.s_ready}, 32'd1);
    endtask

    initial begin
        int stalls;
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_m_data", {21'd0, bus.m_data}, 32'd0);
        chk("rst_m_count", {24'd0, bus.m_count}, 32'd0);
        chk("rst_m_err", {31'd0, bus.m_range_err}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_s_ready", {31'd0, bus.s_ready}, 32'd1);

        // 2010 + 1 wraps to 0
        send(11'd2010, 1'b0);
        send(11'd1, 1'b1);
        recv("wrap", 11'd0, 8'd2, 1'b0);

        // 2100 mod 2011 = 89
        send(11'd1000, 1'b0);
        send(11'd1000, 1'b0);
        send(11'd100, 1'b1);
        recv("three", 11'd89, 8'd3, 1'b0);

        // 2047 reduces to 36 and flags range error; flag does not leak
        send(11'd2047, 1'b1);
        recv("oor", 11'd36, 8'd1, 1'b1);
        send(11'd5, 1'b1);
        recv("after_oor", 11'd5, 8'd1, 1'b0);

        // Backpressure with a term waiting at the input the whole time
        send(11'd7, 1'b0);
        send(11'd8, 1'b1);
        bus.s_valid = 1'b1;
        bus.s_data  = 11'd9;
        bus.s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, bus.m_valid}, 32'd1);
            chk("bp_data", {21'd0, bus.m_data}, 32'd15);
            chk("bp_count", {24'd0, bus.m_count}, 32'd2);
            chk("bp_s_ready", {31'd0, bus.s_ready}, 32'd0);
            step();
        end
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk("bp_rel_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("bp_rel_s_ready", {31'd0, bus.s_ready}, 32'd1);
        step();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("bp_next_latency", {31'd0, bus.m_valid}, 32'd1);
        recv("bp_next", 11'd9, 8'd1, 1'b0);

        // Reset mid-frame discards the partial sum
        send(11'd500, 1'b0);
        send(11'd600, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk("midrst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        send(11'd3, 1'b1);
        recv("midrst", 11'd3, 8'd1, 1'b0);

        // 300 back-to-back terms of 1: count saturates, no stalls
        stalls = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = 11'd1;
        for (int i = 0; i < 300; i++) begin
            bus.s_last = (i == 299);
            if (!bus.s_ready) stalls++;
            step();
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("long_stalls", stalls, 32'd0);
        chk("long_latency", {31'd0, bus.m_valid}, 32'd1);
        recv("long", 11'd300, 8'd255, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mod2011_residue_acc.md
# mod2011_residue_acc

Streaming modular accumulator for the mod-2011 converter path. It consumes the 11-bit partial residues produced by the per-chunk 6-input residue LUTs (one term per operand chunk) and sums them modulo 2011. It emits one fully reduced residue per frame. It sits between the LUT bank and the residue-domain datapath, and is the consuming end of the LUT output interface.

## Interface
- `MOD`, 2011, modulus; must satisfy 2^(W-1) < MOD < 2^W
- `W`, 11, residue width
- `CW`, 8, term-count width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `s_valid`  in  1  input term valid
- `s_ready`  out  1  block can accept a term
- `s_data`  in  W  partial residue, nominally < MOD
- `s_last`  in  1  final term of the frame
- `m_valid`  out  1  result valid
- `m_ready`  in  1  downstream accepts result
- `m_data`  out  W  frame residue, always < MOD
- `m_count`  out  CW  terms in the frame, saturating at 2^CW-1
- `m_range_err`  out  1  at least one term in the frame was >= MOD

## Operation
- **Beat acceptance.** A beat is accepted on a rising edge where `s_valid && s_ready`.
- **Term reduction.** Each accepted term is first reduced: d' = (d >= MOD) ? d - MOD : d. One subtraction is sufficient because 2^W - 1 < 2·MOD. A term with d >= MOD sets the frame's range-error flag.
- **Modular add.** sum = acc + d' is computed in W+1 bits. acc_next = (sum >= MOD) ? sum - MOD : sum.
- **State machine.** There are three states: IDLE, ACCUM and DONE.
  - IDLE: acc = 0, cnt = 0, err = 0.
  - IDLE or ACCUM, beat accepted with s_last=0: update acc, cnt and err, then go to ACCUM.
  - IDLE or ACCUM, beat accepted with s_last=1: load m_data = acc_next, m_count = cnt+1 (saturating), m_range_err = err | this term's error. Then clear acc, cnt and err, and go to DONE.
  - DONE: m_valid=1. On m_ready, go to IDLE.
- **s_ready.** s_ready = (state != DONE). It does not depend combinationally on m_ready.
- **Single-beat frame.** A frame that is a single beat with s_last=1 yields the reduced term itself.
- **Count saturation.** cnt saturates at 2^CW-1. Saturation has no effect on the arithmetic.
- **Output stability.** m_data, m_count and m_range_err are held stable while m_valid=1 and m_ready=0.
- **Reset.** Reset mid-frame discards the partial sum. Reset while in DONE drops the pending result. No beat is accepted in the reset cycle.

## Timing
- **Reset values.** s_ready=0 during the reset cycle, and 1 from the first cycle after reset release. m_valid=0, m_data=0, m_count=0, m_range_err=0. State is IDLE.
- **Throughput.** One term per cycle while in IDLE or ACCUM.
- **Latency.** A last beat accepted at edge N gives m_valid=1 from edge N. The first beat of the next frame can be accepted at edge N+2 at the earliest, provided m_ready=1 at edge N+1. This gives a one-cycle bubble per frame.
- **Output register.** All outputs are registered. The only combinational path is the mod-add, which is a single adder plus a compare/subtract in one cycle.
- **Simultaneous s_valid and m_ready in DONE.** The term is not accepted (s_ready=0), and the state moves to IDLE.

## Structure
- **Shared package `mod2011_pkg`.** Holds `MOD_2011` = 11'd2011, `RES_W` = 11, and the residue typedef `res_t` (logic [10:0]). The parameter defaults in this block come from this package.
- **Sub-module `mod2011_add`.** Combinational, with inputs a and b (each < MOD) and output (a+b) mod MOD. It is instantiated once for the accumulate step and reused by the downstream residue adders. The single-subtract term reduction stays inline.
- **Top level.** Contains the FSM, the acc/cnt/err registers and the output register.

## Test plan
- **Two-term wrap.** Terms 2010, then 1 (last) -> m_data=0, m_count=2, m_range_err=0.
- **Three-term reduction.** Terms 1000, 1000, 100 (last) -> m_data=89, m_count=3.
- **Out-of-range term.** Single term 2047 (last) -> m_data=36, m_count=1, m_range_err=1. The next frame of 5 (last) -> m_data=5, m_range_err=0.
- **Backpressure.**
  - Setup: hold m_ready=0 for 5 cycles after a frame of 7, 8 (last).
  - Required: m_data=15 stays stable and s_ready=0 throughout.
  - Release: when m_ready rises, m_valid drops next edge and s_ready=1.
- **Reset mid-frame.** Terms 500, 600, then rst_n=0 for one cycle, then 3 (last) -> m_data=3, m_count=1.
- **Long frame.** 300 terms of 1 -> m_data=300, m_count=255 (saturated), with throughput of one beat per cycle.
